// File: rtl/oled_microcode_sequencer.sv
// Microcode sequencer for SPI OLED panels: fetches 10-bit words from an external ROM and either
// ships them as SPI bytes or executes them locally (pins, delay, jump, call/return, loop, stop).
module oled_microcode_sequencer #(
    parameter int                  PROG_DEPTH      = 64,
    parameter int                  STACK_DEPTH     = 2,
    parameter int                  NUM_PINS        = 4,
    parameter logic [NUM_PINS-1:0] PIN_RESET_VALUE = NUM_PINS'(4'b1110),
    parameter int                  DELAY_SHIFT     = 11,
    localparam int                 ADDR_BITS       = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic [ADDR_BITS-1:0] procedure_offset_in,
    input  logic                 procedure_start_in,
    input  logic                 abort_in,
    output logic                 procedure_done_out,
    output logic                 error_out,
    output logic [ADDR_BITS-1:0] prog_addr_out,
    input  logic [9:0]           prog_data_in,
    output logic                 spi_tx_trigger_out,
    output logic [7:0]           spi_data_out,
    output logic                 spi_last_byte_out,
    input  logic                 spi_ready_in,
    output logic [NUM_PINS-1:0]  pins_out
);
    // Addresses are range-checked in 7 bits so pc+1 and 6-bit targets never wrap before the check.
    localparam int                 XA         = 7;
    localparam int                 SP_BITS    = $clog2(STACK_DEPTH + 1);
    localparam int                 DCNT_BITS  = 6 + DELAY_SHIFT;
    localparam logic [XA-1:0]      DEPTH_X    = XA'(PROG_DEPTH);
    localparam logic [SP_BITS-1:0] STACK_X    = SP_BITS'(STACK_DEPTH);
    localparam logic [4:0]         NUM_PINS_X = 5'(NUM_PINS);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT, S_DELAY} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d;
    logic [SP_BITS-1:0]     sp_q, sp_d, sp_m1;
    logic [5:0]             loop_cnt_q, loop_cnt_d;
    logic [DCNT_BITS-1:0]   delay_cnt_q, delay_cnt_d;
    logic                   error_q, error_d;
    logic                   abort_pend_q, abort_pend_d;
    logic [NUM_PINS-1:0]    pins_q, pins_d;
    logic [XA-1:0]          stack_q [2**SP_BITS];

    logic [2:0]             opcode;
    logic [5:0]             operand;
    logic [3:0]             pin_idx;
    logic [XA-1:0]          pc_inc, new_pc;
    logic                   go_pc, fault, pin_we, push_en;

    assign opcode  = prog_data_in[8:6];
    assign operand = prog_data_in[5:0];
    assign pin_idx = prog_data_in[4:1];
    assign pc_inc  = XA'(pc_q) + 7'd1;
    assign sp_m1   = sp_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        loop_cnt_d   = loop_cnt_q;
        delay_cnt_d  = delay_cnt_q;
        error_d      = error_q;
        abort_pend_d = abort_pend_q;
        go_pc        = 1'b0;
        new_pc       = pc_inc;
        fault        = 1'b0;
        pin_we       = 1'b0;
        push_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (procedure_start_in && spi_ready_in) begin
                    if (XA'(procedure_offset_in) >= DEPTH_X) begin
                        error_d = 1'b1;
                    end else begin
                        pc_d         = procedure_offset_in;
                        sp_d         = '0;
                        error_d      = 1'b0;
                        abort_pend_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (abort_in) begin
                    state_d = S_IDLE;
                end else if (!prog_data_in[9]) begin
                    state_d = S_SEND;
                end else begin
                    go_pc = 1'b1;
                    case (opcode)
                        3'b000: begin
                            if (operand == 6'd1) begin
                                go_pc   = 1'b0;
                                state_d = S_IDLE;
                            end else if (operand == 6'd2) begin
                                if (sp_q == '0) begin
                                    fault = 1'b1;
                                end else begin
                                    sp_d   = sp_m1;
                                    new_pc = stack_q[sp_m1];
                                end
                            end else if (operand != 6'd0) begin
                                fault = 1'b1;
                            end
                        end
                        3'b001: begin
                            if ({1'b0, pin_idx} >= NUM_PINS_X) fault = 1'b1;
                            else                               pin_we = 1'b1;
                        end
                        3'b010: begin
                            go_pc       = 1'b0;
                            delay_cnt_d = DCNT_BITS'(operand) << DELAY_SHIFT;
                            state_d     = S_DELAY;
                        end
                        3'b011: loop_cnt_d = operand;
                        3'b100: new_pc = XA'(operand);
                        3'b101: begin
                            if (sp_q == STACK_X) begin
                                fault = 1'b1;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + 1'b1;
                                new_pc  = XA'(operand);
                            end
                        end
                        3'b110: begin
                            if (loop_cnt_q != '0) begin
                                loop_cnt_d = loop_cnt_q - 1'b1;
                                new_pc     = XA'(operand);
                            end
                        end
                        default: fault = 1'b1;
                    endcase
                end
            end
            S_SEND: begin
                if (abort_in)           state_d = S_IDLE;
                else if (!spi_ready_in) state_d = S_WAIT;
            end
            S_WAIT: begin
                // An abort seen mid-byte is parked until the shifter finishes.
                if (spi_ready_in) begin
                    abort_pend_d = 1'b0;
                    if (abort_in || abort_pend_q) begin
                        state_d = S_IDLE;
                    end else begin
                        go_pc   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (abort_in) begin
                    abort_pend_d = 1'b1;
                end
            end
            S_DELAY: begin
                if (abort_in) begin
                    state_d = S_IDLE;
                end else if (delay_cnt_q == '0) begin
                    go_pc   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    delay_cnt_d = delay_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A faulting word has no side effects: only error_out and the return to IDLE remain.
        if (go_pc && (new_pc >= DEPTH_X)) fault = 1'b1;
        if (fault) begin
            state_d     = S_IDLE;
            error_d     = 1'b1;
            pc_d        = pc_q;
            sp_d        = sp_q;
            loop_cnt_d  = loop_cnt_q;
            delay_cnt_d = delay_cnt_q;
            pin_we      = 1'b0;
            push_en     = 1'b0;
        end else if (go_pc) begin
            pc_d = new_pc[ADDR_BITS-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            assign pins_d[gi] = (pin_we && (pin_idx == 4'(gi))) ? prog_data_in[0] : pins_q[gi];
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            sp_q         <= '0;
            loop_cnt_q   <= '0;
            delay_cnt_q  <= '0;
            error_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            pins_q       <= PIN_RESET_VALUE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            loop_cnt_q   <= loop_cnt_d;
            delay_cnt_q  <= delay_cnt_d;
            error_q      <= error_d;
            abort_pend_q <= abort_pend_d;
            pins_q       <= pins_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_en && !reset_in) stack_q[sp_q] <= pc_inc;
    end

    assign procedure_done_out = (state_q == S_IDLE);
    assign spi_tx_trigger_out = (state_q == S_SEND);
    assign error_out          = error_q;
    assign prog_addr_out      = pc_q;
    assign spi_data_out       = prog_data_in[7:0];
    assign spi_last_byte_out  = prog_data_in[8];
    assign pins_out           = pins_q;
endmodule

// File: tb/tb_oled_microcode_sequencer.sv
// Bench for oled_microcode_sequencer: directed programs, a vector table of single-run outcomes,
// and random programs checked against an instruction-level interpreter.
module tb_oled_microcode_sequencer;
    localparam int DEPTH = 48;
    localparam int STK   = 1;
    localparam int NP    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] offset;
    logic       start, abort_s;
    logic       done, err, trig, last;
    logic [5:0] addr;
    logic [9:0] pdata;
    logic [7:0] sdata;
    logic [3:0] pins;
    logic       ready_man = 1'b1;
    logic       ready_auto = 1'b1;
    logic       ready;
    bit         manual = 1'b0;
    int         busy = 0;

    logic [9:0] mem [64];
    logic [8:0] rx_q [$];
    logic [8:0] exp_q [$];
    int         hist [64];
    int         checks = 0;
    int         errors = 0;

    assign pdata = mem[addr];
    assign ready = manual ? ready_man : ready_auto;
    always #5 clk = ~clk;

    oled_microcode_sequencer #(
        .PROG_DEPTH(DEPTH), .STACK_DEPTH(STK), .NUM_PINS(NP),
        .PIN_RESET_VALUE(4'b1110), .DELAY_SHIFT(2)
    ) dut (
        .clk_in(clk), .reset_in(rst), .procedure_offset_in(offset),
        .procedure_start_in(start), .abort_in(abort_s), .procedure_done_out(done),
        .error_out(err), .prog_addr_out(addr), .prog_data_in(pdata),
        .spi_tx_trigger_out(trig), .spi_data_out(sdata), .spi_last_byte_out(last),
        .spi_ready_in(ready), .pins_out(pins)
    );

    // SPI shifter stand-in: takes the byte on trigger, then stays busy for a random time.
    always @(negedge clk) begin
        if (!manual && !rst) begin
            if (busy > 0) begin
                busy = busy - 1;
                if (busy == 0) ready_auto = 1'b1;
            end else if (trig && ready_auto) begin
                rx_q.push_back({last, sdata});
                ready_auto = 1'b0;
                busy = $urandom_range(1, 4);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_proc(input logic [5:0] off);
        @(negedge clk);
        offset = off;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        for (int i = 0; i < 64; i++) hist[i] = 0;
        while (!done) begin
            hist[addr]++;
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    // Instruction-level interpreter: outcome of one procedure (bytes, pins, loop count, error).
    task automatic model_run(input int off, inout logic [3:0] pins_m, inout logic [5:0] loop_m,
                             output bit err_m, output bit ok);
        int pc, nxt, idx;
        int stk [$];
        logic [9:0] w;
        logic [3:0] p_new;
        logic [5:0] lc_new;
        exp_q.delete();
        err_m = 1'b0;
        ok    = 1'b0;
        if (off >= DEPTH) begin
            err_m = 1'b1;
            ok    = 1'b1;
            return;
        end
        pc = off;
        for (int step = 0; step < 400; step++) begin
            w = mem[pc];
            nxt = pc + 1;
            p_new = pins_m;
            lc_new = loop_m;
            if (!w[9]) begin
                exp_q.push_back(w[8:0]);
            end else begin
                case (w[8:6])
                    3'd0: begin
                        if (w[5:0] == 6'd1) begin
                            ok = 1'b1;
                            return;
                        end else if (w[5:0] == 6'd2) begin
                            if (stk.size() == 0) err_m = 1'b1;
                            else nxt = stk.pop_back();
                        end else if (w[5:0] != 6'd0) begin
                            err_m = 1'b1;
                        end
                    end
                    3'd1: begin
                        idx = int'(w[4:1]);
                        if (idx >= NP) err_m = 1'b1;
                        else p_new[idx] = w[0];
                    end
                    3'd2: ;
                    3'd3: lc_new = w[5:0];
                    3'd4: nxt = int'(w[5:0]);
                    3'd5: begin
                        if (stk.size() >= STK) err_m = 1'b1;
                        else begin
                            stk.push_back(pc + 1);
                            nxt = int'(w[5:0]);
                        end
                    end
                    3'd6: begin
                        if (loop_m != 6'd0) begin
                            lc_new = loop_m - 6'd1;
                            nxt = int'(w[5:0]);
                        end
                    end
                    default: err_m = 1'b1;
                endcase
            end
            if (nxt >= DEPTH) err_m = 1'b1;
            if (err_m) begin
                ok = 1'b1;
                return;
            end
            pins_m = p_new;
            loop_m = lc_new;
            pc = nxt;
        end
    endtask

    function automatic logic [9:0] rand_word();
        int r;
        logic [2:0] op;
        logic [5:0] opd;
        logic [9:0] w;
        r = $urandom_range(0, 99);
        op = 3'd0;
        opd = 6'($urandom_range(0, 47));
        if (r < 30) begin
            w = {2'b00, 8'($urandom)};
            w[8] = ($urandom_range(0, 3) == 0);
            return w;
        end
        if (r < 40)      begin op = 3'd1; opd = {1'b0, 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1))}; end
        else if (r < 48) begin op = 3'd3; opd = 6'($urandom_range(0, 3)); end
        else if (r < 56) op = 3'd6;
        else if (r < 62) begin op = 3'd4; opd = 6'($urandom_range(0, 49)); end
        else if (r < 70) op = 3'd5;
        else if (r < 77) opd = 6'd2;
        else if (r < 83) begin op = 3'd2; opd = 6'($urandom_range(0, 1)); end
        else if (r < 87) opd = 6'd0;
        else if (r < 97) opd = 6'd1;
        else if (r < 99) op = 3'd7;
        else opd = 6'd5;
        return {1'b1, op, opd};
    endfunction

    typedef struct {
        int         off;
        bit         exp_err;
        logic [3:0] exp_pins;
        int         exp_n;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cyc, base, off;
        bit to, seen, ok, e;
        logic [3:0] m_pins, p;
        logic [5:0] m_loop, lc;

        vecs[0] = '{3,  1'b1, 4'b1111, 0};
        vecs[1] = '{4,  1'b1, 4'b1111, 0};
        vecs[2] = '{5,  1'b1, 4'b1111, 0};
        vecs[3] = '{6,  1'b1, 4'b1111, 0};
        vecs[4] = '{7,  1'b1, 4'b1111, 0};
        vecs[5] = '{8,  1'b0, 4'b1011, 0};
        vecs[6] = '{47, 1'b1, 4'b1011, 1};
        vecs[7] = '{50, 1'b1, 4'b1011, 0};
        vecs[8] = '{24, 1'b0, 4'b1111, 1};
        vecs[9] = '{29, 1'b0, 4'b1111, 0};

        for (int i = 0; i < 64; i++) mem[i] = 10'h201;
        mem[0]  = 10'h241; mem[1]  = 10'h0AE; mem[2]  = 10'h201;
        mem[3]  = 10'h3C0; mem[4]  = 10'h33F; mem[5]  = 10'h202; mem[6] = 10'h203;
        mem[7]  = 10'h24A; mem[8]  = 10'h244; mem[9]  = 10'h201;
        mem[10] = 10'h283; mem[11] = 10'h280; mem[12] = 10'h201;
        mem[20] = 10'h2C2; mem[21] = 10'h1FF; mem[22] = 10'h395; mem[23] = 10'h201;
        mem[24] = 10'h245; mem[25] = 10'h31B; mem[26] = 10'h201; mem[27] = 10'h1AA;
        mem[28] = 10'h201; mem[29] = 10'h201;
        mem[30] = 10'h368; mem[31] = 10'h368; mem[32] = 10'h201;
        mem[33] = 10'h36A; mem[34] = 10'h201;
        mem[40] = 10'h040; mem[41] = 10'h202; mem[42] = 10'h368;
        mem[45] = 10'h055; mem[46] = 10'h201; mem[47] = 10'h011;

        rst = 1'b1; start = 1'b0; abort_s = 1'b0; offset = '0;
        repeat (3) @(negedge clk);
        check("rst_done", done, 1);
        check("rst_trigger", trig, 0);
        check("rst_error", err, 0);
        check("rst_pins", pins, 4'b1110);
        check("rst_addr", addr, 0);
        rst = 1'b0;

        // SET_PIN(0,1), byte 0xAE, STOP
        base = rx_q.size();
        start_proc(6'd0);
        check("a_fetch_addr", addr, 0);
        check("a_pin_before", pins[0], 0);
        @(negedge clk);
        check("a_pin_after", pins[0], 1);
        wait_done(200, cyc, to);
        check("a_timeout", to, 0);
        check("a_nbytes", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("a_byte", rx_q[base], 9'h0AE);
        check("a_error", err, 0);
        $display("run a: bytes=%0d err=%0b pins=%b", rx_q.size() - base, err, pins);

        // DELAY 3 then DELAY 0: fetch cycle plus (v<<2)+1 delay cycles at the same address
        start_proc(6'd10);
        wait_done(200, cyc, to);
        check("b_timeout", to, 0);
        check("b_delay3_cycles", hist[10], 14);
        check("b_delay0_cycles", hist[11], 2);
        $display("run b: addr10=%0d addr11=%0d", hist[10], hist[11]);

        // LOOP_SET 2 around a final-flagged 0xFF
        base = rx_q.size();
        start_proc(6'd20);
        wait_done(400, cyc, to);
        check("c_timeout", to, 0);
        check("c_nbytes", rx_q.size() - base, 3);
        for (int i = base; i < rx_q.size(); i++) check("c_byte", rx_q[i], 9'h1FF);
        check("c_error", err, 0);
        $display("run c: bytes=%0d err=%0b", rx_q.size() - base, err);

        // Two calls with a one-entry stack, then a nested call overflowing it
        base = rx_q.size();
        start_proc(6'd30);
        wait_done(400, cyc, to);
        check("d_timeout", to, 0);
        check("d_nbytes", rx_q.size() - base, 2);
        for (int i = base; i < rx_q.size(); i++) check("d_byte", rx_q[i], 9'h040);
        check("d_error", err, 0);
        base = rx_q.size();
        start_proc(6'd33);
        wait_done(400, cyc, to);
        check("d_nest_error", err, 1);
        check("d_nest_done", done, 1);
        check("d_nest_nbytes", rx_q.size() - base, 0);
        $display("run d: nested err=%0b", err);

        for (int v = 0; v < 10; v++) begin
            base = rx_q.size();
            start_proc(6'(vecs[v].off));
            wait_done(400, cyc, to);
            check($sformatf("t%0d_timeout", v), to, 0);
            check($sformatf("t%0d_error", v), err, vecs[v].exp_err);
            check($sformatf("t%0d_pins", v), pins, vecs[v].exp_pins);
            check($sformatf("t%0d_nbytes", v), rx_q.size() - base, vecs[v].exp_n);
            check($sformatf("t%0d_done", v), done, 1);
            $display("vec %0d: off=%0d err=%0b pins=%b bytes=%0d", v, vecs[v].off, err, pins,
                     rx_q.size() - base);
        end

        // Abort while the shifter is busy: held until ready returns, then straight to IDLE
        manual = 1'b1;
        ready_man = 1'b1;
        start_proc(6'd45);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (trig) seen = 1'b1;
            else @(negedge clk);
        end
        check("e_trigger", seen, 1);
        check("e_byte", sdata, 8'h55);
        ready_man = 1'b0;
        @(negedge clk);
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("e_hold_wait", done, 0);
            @(negedge clk);
        end
        ready_man = 1'b1;
        @(negedge clk);
        check("e_idle_after_ready", done, 1);
        check("e_no_error", err, 0);
        check("e_pc_held", addr, 45);
        manual = 1'b0;
        $display("run e: done=%0b err=%0b addr=%0d", done, err, addr);

        // Reset in the middle of a delay
        start_proc(6'd10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("f_rst_done", done, 1);
        check("f_rst_trigger", trig, 0);
        check("f_rst_pins", pins, 4'b1110);
        rst = 1'b0;
        $display("run f: done=%0b pins=%b", done, pins);

        m_pins = 4'b1110;
        m_loop = 6'd0;
        for (int it = 0; it < 40; it++) begin
            ok = 1'b0;
            off = 0;
            e = 1'b0;
            p = m_pins;
            lc = m_loop;
            for (int tries = 0; tries < 50 && !ok; tries++) begin
                for (int a = 0; a < DEPTH; a++) mem[a] = rand_word();
                off = ($urandom_range(0, 19) == 0) ? 48 + $urandom_range(0, 15) : $urandom_range(0, 47);
                p = m_pins;
                lc = m_loop;
                model_run(off, p, lc, e, ok);
            end
            if (!ok) continue;
            base = rx_q.size();
            start_proc(6'(off));
            wait_done(4000, cyc, to);
            check("r_timeout", to, 0);
            check("r_error", err, e);
            check("r_pins", pins, p);
            check("r_nbytes", rx_q.size() - base, exp_q.size());
            for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++)
                check("r_byte", rx_q[base + i], exp_q[i]);
            $display("rand %0d: off=%0d bytes=%0d err=%0b pins=%b", it, off, rx_q.size() - base, err, pins);
            m_pins = p;
            m_loop = lc;
            if (to) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                m_pins = 4'b1110;
                m_loop = 6'd0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/oled_microcode_sequencer.md
Name: oled_microcode_sequencer

Overview:
Parametrised microcode sequencer for SPI-driven OLED panels (SSD1306 family and wider). It fetches 10-bit words from an external combinational program memory. Each word is either sent as an SPI data byte or executed locally: pin control, delay, jump, call/return, counted loop, stop. It sits between the display controller FSM, the program ROM and the SPI shift register. Compared with the previous executor, it adds subroutines, loops, a configurable pin bank, a delay prescale, abort and error reporting.

Parameters:
PROG_DEPTH, 64, program words; legal range 2..64 (6-bit jump field).
ADDR_BITS, $clog2(PROG_DEPTH), program counter width (localparam).
STACK_DEPTH, 2, return-address stack entries, 1..8.
NUM_PINS, 4, controlled output pins, 1..16.
PIN_RESET_VALUE, 4'b1110, reset/initial value of pins_out (bit0 = panel reset_n, low).
DELAY_SHIFT, 11, left shift applied to the DELAY operand.

Ports:
clk_in  in  1  clock
reset_in  in  1  synchronous active-high reset
procedure_offset_in  in  ADDR_BITS  start address of procedure
procedure_start_in  in  1  start request (level, sampled in IDLE)
abort_in  in  1  abort running procedure
procedure_done_out  out  1  high while IDLE
error_out  out  1  sticky error flag, cleared by the next accepted start
prog_addr_out  out  ADDR_BITS  program memory address (= pc)
prog_data_in  in  10  program word, combinational, valid in the same cycle
spi_tx_trigger_out  out  1  high while in SEND
spi_data_out  out  8  prog_data_in[7:0]
spi_last_byte_out  out  1  prog_data_in[8]
spi_ready_in  in  1  SPI shifter idle
pins_out  out  NUM_PINS  panel control pins (reset_n, vbat_n, vcd_n, dc, ...)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, pc 0, sp 0, loop_cnt 0, delay_cnt 0, error_out 0, pins_out PIN_RESET_VALUE. procedure_done_out=1 and spi_tx_trigger_out=0 after the reset edge. Reset mid-operation aborts immediately, including during SEND/WAIT.
- Word format:
  - bit9=0: data byte [7:0]; bit8 = last-byte flag.
  - bit9=1: local instruction, opcode [8:6], operand [5:0]:
    - 000: operand 0 NOP, 1 STOP, 2 RET; other operands are errors.
    - 001: SET_PIN; [4:1] pin index, [0] value; index >= NUM_PINS is an error.
    - 010: DELAY v.
    - 011: LOOP_SET n, sets loop_cnt = n.
    - 100: JMP a.
    - 101: CALL a.
    - 110: DJNZ a; if loop_cnt != 0, decrement and jump to a, else fall through.
    - 111: reserved, error.
- States: IDLE, FETCH, SEND, WAIT, DELAY.
- IDLE: when procedure_start_in && spi_ready_in, set pc = offset, sp = 0, error_out = 0, and go to FETCH next cycle. An offset >= PROG_DEPTH sets error and stays in IDLE.
- FETCH (one cycle per word, no retire cycle):
  - Data word: go to SEND.
  - NOP, SET_PIN, LOOP_SET: pc+1, stay in FETCH. Pin change is visible next cycle.
  - JMP: pc = a.
  - CALL: push pc+1, then pc = a; if sp == STACK_DEPTH, error.
  - RET: pop into pc; if sp == 0, error.
  - DJNZ: as encoded above.
  - STOP: go to IDLE.
  - DELAY: delay_cnt = v << DELAY_SHIFT, go to DELAY.
- SEND: trigger is high. When spi_ready_in = 0, go to WAIT. WAIT: when spi_ready_in = 1, pc+1 and go to FETCH.
- DELAY: decrement each cycle; at delay_cnt == 0, pc+1 and go to FETCH. DELAY occupies (v << DELAY_SHIFT) + 1 cycles; v = 0 gives 1 cycle.
- Any next pc >= PROG_DEPTH, including running off the end or a bad jump/call target: error.
- Error (any cause): error_out = 1, go to IDLE; pins hold their values.
- abort_in: from FETCH/SEND/DELAY, go to IDLE next cycle. In WAIT, abort is remembered and taken once spi_ready_in = 1, so a byte is never truncated. abort_in is ignored in IDLE. Abort does not set error.
- Loops do not nest (one loop_cnt). The stack is not cleared by STOP; it is cleared by start.
- Simultaneous reset and start: reset wins. Start and abort together in IDLE: start wins.

Test Plan:
- Reset, then program at 0: SET_PIN(0,1), 0x0AE, STOP -> pins_out[0] rises 1 cycle after FETCH; one trigger with spi_data_out=0xAE; done_out=1 after STOP; error_out=0.
- DELAY v=3 with DELAY_SHIFT=2 -> DELAY state lasts exactly 13 cycles; v=0 -> 1 cycle.
- LOOP_SET 2, data 0x1FF, DJNZ back -> exactly 3 SPI bytes 0xFF, each with last=1.
- CALL sub (sends 0x40, RET) twice from main, STACK_DEPTH=1 -> 2 bytes sent, no error. Nested CALL in sub -> error_out=1, IDLE.
- abort_in asserted in WAIT with spi_ready_in low for 5 cycles -> stays in WAIT until ready rises, then IDLE on the next cycle.
- Reserved opcode 0x3C0, and a JMP to 63 with PROG_DEPTH=48 -> error_out=1, done_out=1. The next start clears error_out.
